fetch_stage: RTL and testbench



---
 rtl/fetch_stage_if.sv | 25 ++
 rtl/fetch_stage.sv | 128 ++++++++++++
 tb/tb_fetch_stage.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: instruction ROM port, hazard/redirect controls and IF/ID outputs.
// The master modport is the fetch stage itself; the slave modport is the surrounding pipeline.
interface fetch_stage_if;
   logic        stall;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] irom_inst;
   logic [31:0] irom_addr;
   logic [31:0] id_inst;
   logic [31:0] id_pc;
   logic [31:0] id_pc4;
   logic        id_valid;
   logic [31:0] fetch_cnt;
   logic [31:0] bubble_cnt;

   modport master (
      input  stall, redirect_valid, redirect_pc, irom_inst,
      output irom_addr, id_inst, id_pc, id_pc4, id_valid, fetch_cnt, bubble_cnt
   );

   modport slave (
      output stall, redirect_valid, redirect_pc, irom_inst,
      input  irom_addr, id_inst, id_pc, id_pc4, id_valid, fetch_cnt, bubble_cnt
   );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, ROM address, IF/ID register with stall/redirect handling.
// Optional macro FETCH_PERF_CNT_EN adds fetched-instruction and bubble counters.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] BUBBLE   = 32'h0000_0000
) (
   input  logic          clk,
   input  logic          rst,
   fetch_stage_if.master bus
);

   typedef enum logic [0:0] {
      BOOT = 1'b0,
      RUN  = 1'b1
   } state_e;

   state_e      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] id_inst_q, id_inst_d;
   logic [31:0] id_pc_q, id_pc_d;
   logic [31:0] id_pc4_q, id_pc4_d;
   logic        id_valid_q, id_valid_d;
   logic        load_inst_s;
   logic        load_bubble_s;

   // Next-state logic: redirect beats stall, BOOT spends one edge before fetching.
   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      id_inst_d     = id_inst_q;
      id_pc_d       = id_pc_q;
      id_pc4_d      = id_pc4_q;
      id_valid_d    = id_valid_q;
      load_inst_s   = 1'b0;
      load_bubble_s = 1'b0;
      case (state_q)
         BOOT: begin
            state_d = RUN;
         end
         RUN: begin
            if (bus.redirect_valid) begin
               pc_d          = bus.redirect_pc & 32'hFFFF_FFFC;
               id_inst_d     = BUBBLE;
               id_valid_d    = 1'b0;
               load_bubble_s = 1'b1;
            end else if (bus.stall) begin
               pc_d = pc_q;
            end else begin
               id_inst_d   = bus.irom_inst;
               id_pc_d     = pc_q;
               id_pc4_d    = pc_q + 32'd4;
               id_valid_d  = 1'b1;
               pc_d        = pc_q + 32'd4;
               load_inst_s = 1'b1;
            end
         end
         default: begin
            state_d = BOOT;
         end
      endcase
   end

   // State, PC and IF/ID registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= BOOT;
         pc_q       <= RESET_PC;
         id_inst_q  <= BUBBLE;
         id_pc_q    <= 32'h0000_0000;
         id_pc4_q   <= 32'h0000_0004;
         id_valid_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         id_inst_q  <= id_inst_d;
         id_pc_q    <= id_pc_d;
         id_pc4_q   <= id_pc4_d;
         id_valid_q <= id_valid_d;
      end
   end

   assign bus.irom_addr = {pc_q[31:2], 2'b00};
   assign bus.id_inst   = id_inst_q;
   assign bus.id_pc     = id_pc_q;
   assign bus.id_pc4    = id_pc4_q;
   assign bus.id_valid  = id_valid_q;

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] fetch_cnt_q, fetch_cnt_d;
   logic [31:0] bubble_cnt_q, bubble_cnt_d;

   // Counter increments; both wrap naturally at 32 bits.
   always_comb begin
      fetch_cnt_d  = fetch_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (load_inst_s) begin
         fetch_cnt_d = fetch_cnt_q + 32'd1;
      end else begin
         fetch_cnt_d = fetch_cnt_q;
      end
      if (load_bubble_s) begin
         bubble_cnt_d = bubble_cnt_q + 32'd1;
      end else begin
         bubble_cnt_d = bubble_cnt_q;
      end
   end

   // Performance counter registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_cnt_q  <= 32'h0000_0000;
         bubble_cnt_q <= 32'h0000_0000;
      end else begin
         fetch_cnt_q  <= fetch_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign bus.fetch_cnt  = fetch_cnt_q;
   assign bus.bubble_cnt = bubble_cnt_q;
`else
   logic unused_load_s;
   assign unused_load_s  = load_inst_s ^ load_bubble_s;
   assign bus.fetch_cnt  = 32'h0000_0000;
   assign bus.bubble_cnt = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized stall/redirect
// traffic checked against a transaction-level model of the fetch stage.
module tb_fetch_stage;

   logic clk;
   logic rst;
   fetch_stage_if bus();

   fetch_stage u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] rom(input logic [31:0] a);
      if (a == 32'h0000_0000) return 32'h0010_0093;
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   assign bus.irom_inst = rom(bus.irom_addr);

   int n_cmp = 0;
   int n_err = 0;

   // Reference model: architectural PC and the contents the IF/ID register should hold.
   logic [31:0] m_pc, m_inst, m_idpc, m_idpc4, m_fc, m_bc;
   logic        m_valid, m_boot;

   task automatic model_reset();
      m_pc = 32'h0; m_inst = 32'h0; m_idpc = 32'h0; m_idpc4 = 32'h4;
      m_valid = 1'b0; m_boot = 1'b1; m_fc = 32'h0; m_bc = 32'h0;
   endtask

   task automatic model_step();
      if (m_boot) begin
         m_boot = 1'b0;
      end else if (bus.redirect_valid) begin
         m_pc = {bus.redirect_pc[31:2], 2'b00};
         m_inst = 32'h0; m_valid = 1'b0; m_bc = m_bc + 32'd1;
      end else if (!bus.stall) begin
         m_inst = rom(m_pc); m_idpc = m_pc; m_idpc4 = m_pc + 32'd4;
         m_valid = 1'b1; m_pc = m_pc + 32'd4; m_fc = m_fc + 32'd1;
      end
   endtask

   function automatic logic [192:0] obs_vec();
      return {bus.irom_addr, bus.id_inst, bus.id_pc, bus.id_pc4, bus.id_valid,
              bus.fetch_cnt, bus.bubble_cnt};
   endfunction

   function automatic logic [192:0] exp_vec();
      logic [31:0] fc, bc;
`ifdef FETCH_PERF_CNT_EN
      fc = m_fc; bc = m_bc;
`else
      fc = 32'h0; bc = 32'h0;
`endif
      return {m_pc, m_inst, m_idpc, m_idpc4, m_valid, fc, bc};
   endfunction

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic set_in(input logic s, input logic r, input logic [31:0] rp);
      bus.stall = s; bus.redirect_valid = r; bus.redirect_pc = rp;
   endtask

   task automatic do_reset();
      set_in(1'b0, 1'b0, 32'h0);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      do_reset();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
         n_err++; $display("FAIL reset_state got=%h want=%h", obs_vec(), exp_vec());
      end
      tick();
      n_cmp++;
      if (bus.id_inst !== 32'h0 || bus.id_valid !== 1'b0 || obs_vec() !== exp_vec()) begin
         n_err++; $display("FAIL boot_edge got=%h want=%h", obs_vec(), exp_vec());
      end
      tick();
      n_cmp++;
      if (bus.id_inst !== 32'h0010_0093 || bus.id_pc !== 32'h0 || bus.id_pc4 !== 32'h4 ||
          bus.id_valid !== 1'b1 || obs_vec() !== exp_vec()) begin
         n_err++; $display("FAIL first_fetch got=%h want=%h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_boot_ignores_controls();
      do_reset();
      set_in(1'b1, 1'b1, 32'h0000_0200);
      tick();
      n_cmp++;
      if (bus.irom_addr !== 32'h0 || obs_vec() !== exp_vec()) begin
         n_err++; $display("FAIL boot_ignore got=%h want=%h", obs_vec(), exp_vec());
      end
      set_in(1'b0, 1'b0, 32'h0);
   endtask

   task automatic test_sequential();
      do_reset();
      tick();
      for (int k = 0; k < 4; k++) begin
         tick();
         n_cmp++;
         if (bus.id_pc !== 32'(4 * k) || obs_vec() !== exp_vec()) begin
            n_err++; $display("FAIL seq_fetch_%0d got=%h want=%h", k, obs_vec(), exp_vec());
         end
      end
      n_cmp++;
      if (bus.irom_addr !== 32'h10) begin
         n_err++; $display("FAIL seq_addr got=%h want=%h", bus.irom_addr, 32'h10);
      end
   endtask

   task automatic test_stall();
      do_reset();
      repeat (4) tick();
      set_in(1'b1, 1'b0, 32'h0);
      for (int k = 0; k < 3; k++) begin
         tick();
         n_cmp++;
         if (bus.id_pc !== 32'h8 || bus.irom_addr !== 32'hC || obs_vec() !== exp_vec()) begin
            n_err++; $display("FAIL stall_hold_%0d got=%h want=%h", k, obs_vec(), exp_vec());
         end
      end
      set_in(1'b0, 1'b0, 32'h0);
      tick();
      n_cmp++;
      if (bus.id_pc !== 32'hC || obs_vec() !== exp_vec()) begin
         n_err++; $display("FAIL stall_resume got=%h want=%h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_redirect_over_stall();
      set_in(1'b1, 1'b1, 32'h0000_0103);
      tick();
      n_cmp++;
      if (bus.irom_addr !== 32'h100 || bus.id_inst !== 32'h0 || bus.id_valid !== 1'b0 ||
          obs_vec() !== exp_vec()) begin
         n_err++; $display("FAIL redirect_stall got=%h want=%h", obs_vec(), exp_vec());
      end
      set_in(1'b0, 1'b0, 32'h0);
      tick();
      n_cmp++;
      if (bus.id_pc !== 32'h100 || bus.id_valid !== 1'b1 || obs_vec() !== exp_vec()) begin
         n_err++; $display("FAIL redirect_target got=%h want=%h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_async_reset();
      set_in(1'b0, 1'b1, 32'h0000_0040);
      tick();
      set_in(1'b0, 1'b0, 32'h0);
      n_cmp++;
      if (bus.irom_addr !== 32'h40) begin
         n_err++; $display("FAIL async_setup got=%h want=%h", bus.irom_addr, 32'h40);
      end
      #2 rst = 1'b1;
      #1;
      n_cmp++;
      if (bus.irom_addr !== 32'h0 || bus.id_valid !== 1'b0 || bus.fetch_cnt !== 32'h0 ||
          bus.bubble_cnt !== 32'h0 || bus.id_pc4 !== 32'h4 || bus.id_inst !== 32'h0) begin
         n_err++; $display("FAIL async_reset got=%h want=irom 0, valid 0, cnt 0", obs_vec());
      end
      #1 rst = 1'b0;
      model_reset();
      tick();
      tick();
      n_cmp++;
      if (bus.id_inst !== 32'h0010_0093 || obs_vec() !== exp_vec()) begin
         n_err++; $display("FAIL async_restart got=%h want=%h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_wrap();
      set_in(1'b0, 1'b1, 32'hFFFF_FFFC);
      tick();
      set_in(1'b0, 1'b0, 32'h0);
      tick();
      n_cmp++;
      if (bus.id_pc !== 32'hFFFF_FFFC || bus.id_pc4 !== 32'h0 || bus.irom_addr !== 32'h0 ||
          obs_vec() !== exp_vec()) begin
         n_err++; $display("FAIL wrap got=%h want=%h", obs_vec(), exp_vec());
      end
   endtask

   task automatic test_random();
      int bad = 0;
      for (int k = 0; k < 400; k++) begin
         set_in(($urandom_range(99) < 30), ($urandom_range(99) < 15), $urandom());
         tick();
         n_cmp++;
         if (obs_vec() !== exp_vec()) begin
            n_err++;
            if (bad < 10) $display("FAIL random_%0d got=%h want=%h", k, obs_vec(), exp_vec());
            bad++;
         end
      end
      set_in(1'b0, 1'b0, 32'h0);
   endtask

   initial begin
      rst = 1'b1;
      set_in(1'b0, 1'b0, 32'h0);
      model_reset();
      test_reset();
      test_boot_ignores_controls();
      test_sequential();
      test_stall();
      test_redirect_over_stall();
      test_async_reset();
      test_wrap();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
